// File: rtl/vga_pkg.sv
// Shared types and constants for the framebuffer arbiter.
// Pixel format, frame defaults, FSM states and read-return tags.
package vga_pkg;

  localparam int PIX_W = 8;
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  localparam int H_PIX_DEF = 320;
  localparam int V_PIX_DEF = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    TAG_DISP = 1'b0,
    TAG_HOST = 1'b1
  } tag_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host request bus of the framebuffer arbiter.
// master: host side; slave: arbiter side (ready/rvalid/rdata back).
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 17
);
  import vga_pkg::*;

  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  wdata;
  logic              ready;
  logic              rvalid;
  logic [PIX_W-1:0]  rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/vga_pix_fifo.sv
// Show-ahead pixel FIFO; head visible on dout, 0 when empty.
// Ports: push/din, pop, flush, level, empty, underflow (pop on empty).
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [PIX_W-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (level == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && ((level != LW'(DEPTH)) || do_pop);
  assign underflow = pop && empty;
  assign dout      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares the single-port framebuffer between display scanout and host.
// Ports: frame_start/pix_pop in, pix_data/pix_underflow out, host bus, mem_*.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int              H_PIX      = H_PIX_DEF,
  parameter int              V_PIX      = V_PIX_DEF,
  parameter int              ADDR_W     = 17,
  parameter logic [ADDR_W-1:0] FB_BASE  = '0,
  parameter int              FIFO_DEPTH = 8,
  parameter int              LOW_WM     = 3
) (
  input  logic              app_clk,
  input  logic              app_arst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_underflow,
  vga_fb_arbiter_if.slave   host,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);
  localparam int TOTAL = H_PIX * V_PIX;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] WM   = LW'(LOW_WM);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              rd_pend;
  tag_e              rd_tag;

  logic [LW-1:0]     level;
  logic [LW-1:0]     credits;
  logic              disp_ret;
  logic              disp_ok;
  logic              urgent;
  logic              grant_d;
  logic              grant_h;
  logic              fifo_empty;
  logic              uf_pulse;

  // A read returning in a frame_start cycle belongs to the old frame.
  assign disp_ret = rd_pend && (rd_tag == TAG_DISP);
  assign credits  = level + LW'(disp_ret);

  // No display fetch in the frame_start cycle, so nothing stale is issued.
  assign disp_ok = (state == ST_FETCH) && !frame_start;
  assign urgent  = disp_ok && (credits < WM);
  assign grant_h = host.valid && !urgent;
  assign grant_d = urgent || (!host.valid && disp_ok && (credits < FULL));

  assign host.ready  = grant_h;
  assign host.rvalid = rd_pend && (rd_tag == TAG_HOST);
  assign host.rdata  = host.rvalid ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    state_nx  = state;
    unique case (1'b1)
      grant_d: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
      grant_h: begin
        mem_en    = 1'b1;
        mem_we    = host.we;
        mem_addr  = host.addr;
        mem_wdata = host.wdata;
      end
      default: ;
    endcase
    if (frame_start)
      state_nx = ST_FETCH;
    else if (grant_d && (fetch_cnt == CNT_W'(TOTAL - 1)))
      state_nx = ST_DONE;
  end

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      state         <= ST_IDLE;
      fetch_addr    <= FB_BASE;
      fetch_cnt     <= '0;
      rd_pend       <= 1'b0;
      rd_tag        <= TAG_DISP;
      pix_underflow <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= mem_en && !mem_we;
      rd_tag  <= grant_d ? TAG_DISP : TAG_HOST;
      if (uf_pulse)
        pix_underflow <= 1'b1;
      if (frame_start) begin
        fetch_addr <= FB_BASE;
        fetch_cnt  <= '0;
      end else if (grant_d) begin
        fetch_addr <= fetch_addr + 1'b1;
        fetch_cnt  <= fetch_cnt + 1'b1;
      end
    end
  end

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (app_clk),
    .rst_n     (app_arst_n),
    .push      (disp_ret && !frame_start),
    .din       (mem_rdata),
    .pop       (pix_pop && !frame_start),
    .flush     (frame_start),
    .dout      (pix_data),
    .level     (level),
    .empty     (fifo_empty),
    .underflow (uf_pulse)
  );

  logic unused_ok;
  assign unused_ok = fifo_empty;
endmodule
